// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and default sizes for the fetch sequencer
package fetch_pkg;

    localparam int PC_W_DEF      = 9;
    localparam int RAS_DEPTH_DEF = 4;
    localparam int CNT_W_DEF     = 16;

    // Flow class of the instruction currently at PC; codes 6 and 7 are unused
    typedef enum logic [2:0] {
        SEQ  = 3'd0,
        JMP  = 3'd1,
        BR   = 3'd2,
        CALL = 3'd3,
        RET  = 3'd4,
        HALT = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } state_e;

endpackage

// File: rtl/ras_lifo.sv
// rtl/ras_lifo.sv - return-address stack, LIFO with push/pop, top, full/empty
module ras_lifo
    import fetch_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int DEPTH = RAS_DEPTH_DEF
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [PC_W-1:0] data_i,
    output logic [PC_W-1:0] top_o,
    output logic            full_o,
    output logic            empty_o
);

    // One extra pointer bit so that "full" (count == DEPTH) is representable
    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(DEPTH);

    logic [PC_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] cnt_q;
    logic [PTR_W-1:0] cnt_d;
    logic [PTR_W-1:0] top_ptr;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign top_ptr = cnt_q - PTR_W'(1);
    assign top_o   = mem_q[top_ptr[PTR_W-2:0]];

    // Entry count moves by one on an accepted push or pop
    always_comb begin
        cnt_d = cnt_q;
        if (push_i && !full_o) begin
            cnt_d = cnt_q + PTR_W'(1);
        end else if (pop_i && !empty_o) begin
            cnt_d = cnt_q - PTR_W'(1);
        end
    end

    // Pointer register; reset empties the stack without touching storage
    always_ff @(posedge CLK) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Storage write at the slot just above the current top
    always_ff @(posedge CLK) begin
        if (!Reset && push_i && !full_o) begin
            mem_q[cnt_q[PTR_W-2:0]] <= data_i;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch-stage control FSM with flow decode, RAS and retire counter
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int RAS_DEPTH = RAS_DEPTH_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [PC_W-1:0]  Target,
    input  logic             Cond,
    input  logic             Stall_Req,
    input  logic [PC_W-1:0]  PC,
    output logic             Abs_Jump,
    output logic [PC_W-1:0]  Offset,
    output logic             Halt,
    output logic             Done,
    output logic             Err,
    output logic [CNT_W-1:0] Instr_Count
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              retire;
    logic              ras_push, ras_pop;
    logic              ras_full, ras_empty;
    logic [PC_W-1:0]   ras_top;
    logic [PC_W-1:0]   ret_addr;

    // Return address wraps naturally at the top of the PC space
    assign ret_addr = PC + PC_W'(1);

    ras_lifo #(
        .PC_W  (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .CLK     (CLK),
        .Reset   (Reset),
        .push_i  (ras_push),
        .pop_i   (ras_pop),
        .data_i  (ret_addr),
        .top_o   (ras_top),
        .full_o  (ras_full),
        .empty_o (ras_empty)
    );

    // State, retire counter
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Flow decode: PC control for the next edge, RAS requests and next state
    always_comb begin
        state_d  = state_q;
        Halt     = 1'b1;
        Abs_Jump = 1'b0;
        Offset   = '0;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        retire   = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) state_d = RUN;
            end
            RUN: begin
                if (!Stall_Req) begin
                    case (op_e'(Op))
                        JMP: begin
                            Halt     = 1'b0;
                            Abs_Jump = 1'b1;
                            Offset   = Target;
                            retire   = 1'b1;
                        end
                        BR: begin
                            Halt     = 1'b0;
                            Abs_Jump = Cond;
                            Offset   = Cond ? Target : '0;
                            retire   = 1'b1;
                        end
                        CALL: begin
                            if (ras_full) begin
                                state_d = FAULT;
                            end else begin
                                Halt     = 1'b0;
                                Abs_Jump = 1'b1;
                                Offset   = Target;
                                ras_push = 1'b1;
                                retire   = 1'b1;
                            end
                        end
                        RET: begin
                            if (ras_empty) begin
                                state_d = FAULT;
                            end else begin
                                Halt     = 1'b0;
                                Abs_Jump = 1'b1;
                                Offset   = ras_top;
                                ras_pop  = 1'b1;
                                retire   = 1'b1;
                            end
                        end
                        HALT: begin
                            state_d = DONE;
                            retire  = 1'b1;
                        end
                        default: begin
                            Halt   = 1'b0;
                            retire = 1'b1;
                        end
                    endcase
                end
            end
            default: begin
            end
        endcase
    end

    // Saturating retire count
    always_comb begin
        cnt_d = cnt_q;
        if (retire && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end

    assign Done        = (state_q == DONE);
    assign Err         = (state_q == FAULT);
    assign Instr_Count = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer against a queue-based reference model
module tb_fetch_sequencer;

    localparam int PC_W  = 9;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int PC_MOD  = 1 << PC_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             CLK;
    logic             Reset;
    logic             Start;
    logic [2:0]       Op;
    logic [PC_W-1:0]  Target;
    logic             Cond;
    logic             Stall_Req;
    logic [PC_W-1:0]  PC;
    logic             Abs_Jump;
    logic [PC_W-1:0]  Offset;
    logic             Halt;
    logic             Done;
    logic             Err;
    logic [CNT_W-1:0] Instr_Count;

    fetch_sequencer #(.PC_W(PC_W), .RAS_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .Start       (Start),
        .Op          (Op),
        .Target      (Target),
        .Cond        (Cond),
        .Stall_Req   (Stall_Req),
        .PC          (PC),
        .Abs_Jump    (Abs_Jump),
        .Offset      (Offset),
        .Halt        (Halt),
        .Done        (Done),
        .Err         (Err),
        .Instr_Count (Instr_Count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic             halt;
        logic             abs_jump;
        logic [PC_W-1:0]  offset;
        logic             done;
        logic             err;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: program mode, return stack, retired count, fetch PC
    bit   m_running, m_done, m_fault;
    int   m_ras[$];
    int   m_cnt;
    int   m_pc;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: every cycle with a pending expectation is compared at the falling edge
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("Halt", 16'(Halt), 16'(e.halt));
            chk("Abs_Jump", 16'(Abs_Jump), 16'(e.abs_jump));
            if (e.abs_jump) chk("Offset", 16'(Offset), 16'(e.offset));
            chk("Done", 16'(Done), 16'(e.done));
            chk("Err", 16'(Err), 16'(e.err));
            chk("Instr_Count", 16'(Instr_Count), 16'(e.cnt));
        end
    end

    // Drive one cycle, predict its outputs, then advance the model past the edge
    task automatic step(input bit rst, input bit st, input int op, input int tgt,
                        input bit cnd, input bit stl, input bit check);
        exp_t e;
        bit   retired;
        bit   go_idle_run;
        Reset = rst; Start = st; Op = 3'(op); Target = PC_W'(tgt);
        Cond = cnd; Stall_Req = stl; PC = PC_W'(m_pc);
        e.halt = 1'b1; e.abs_jump = 1'b0; e.offset = '0;
        e.done = m_done; e.err = m_fault; e.cnt = CNT_W'(m_cnt);
        retired = 0;
        go_idle_run = !m_running && !m_done && !m_fault && st;
        if (m_running && !stl) begin
            case (op)
                1: begin e.halt = 0; e.abs_jump = 1; e.offset = PC_W'(tgt); retired = 1; end
                2: begin e.halt = 0; e.abs_jump = cnd; e.offset = PC_W'(tgt); retired = 1; end
                3: if (m_ras.size() >= DEPTH) begin
                       m_running = 0; m_fault = 1;
                   end else begin
                       m_ras.push_back((m_pc + 1) % PC_MOD);
                       e.halt = 0; e.abs_jump = 1; e.offset = PC_W'(tgt); retired = 1;
                   end
                4: if (m_ras.size() == 0) begin
                       m_running = 0; m_fault = 1;
                   end else begin
                       e.halt = 0; e.abs_jump = 1; e.offset = PC_W'(m_ras.pop_back()); retired = 1;
                   end
                5: begin m_running = 0; m_done = 1; retired = 1; end
                default: begin e.halt = 0; retired = 1; end
            endcase
        end
        if (check) exp_q.push_back(e);
        @(posedge CLK);
        #1;
        if (go_idle_run) m_running = 1;
        if (retired && m_cnt < CNT_MAX) m_cnt++;
        if (e.abs_jump) m_pc = int'(e.offset);
        else if (!e.halt) m_pc = (m_pc + 1) % PC_MOD;
        if (rst) begin
            m_running = 0; m_done = 0; m_fault = 0;
            m_ras.delete(); m_cnt = 0; m_pc = 0;
        end
    endtask

    task automatic run_op(input int op, input int tgt, input bit cnd);
        step(0, 0, op, tgt, cnd, 0, 1);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        Reset = 1; Start = 0; Op = 0; Target = 0; Cond = 0; Stall_Req = 0; PC = 0;
        m_running = 0; m_done = 0; m_fault = 0; m_cnt = 0; m_pc = 0;
        @(posedge CLK); #1;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);

        // Idle hold
        for (int i = 0; i < 5; i++) step(0, 0, 1, 'h33, 1, 0, 1);

        // Sequential run then jump, branch both ways
        step(0, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) run_op(0, 0, 0);
        run_op(1, 'h40, 0);
        run_op(2, 'h10, 0);
        run_op(2, 'h10, 1);

        // Call from 0x05, stalled return, then return to 0x06
        run_op(1, 'h05, 0);
        run_op(3, 'h80, 0);
        run_op(0, 0, 0);
        step(0, 0, 4, 0, 0, 1, 1);
        step(0, 0, 4, 0, 0, 1, 1);
        run_op(4, 0, 0);
        run_op(6, 0, 0);
        run_op(7, 0, 0);

        // Call at the top of PC space pushes 0
        run_op(1, PC_MOD - 1, 0);
        run_op(3, 'h22, 0);
        run_op(4, 0, 0);

        // Stack overflow on fifth nested call, fault sticky, Start ignored
        do_reset();
        step(0, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) run_op(3, 'h100 + i, 0);
        step(0, 1, 4, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 1);

        // Underflow on return with empty stack
        do_reset();
        step(0, 1, 0, 0, 0, 0, 1);
        run_op(4, 0, 0);
        step(0, 1, 0, 0, 0, 0, 1);

        // Halt then Start ignored, reset clears
        do_reset();
        step(0, 1, 0, 0, 0, 0, 1);
        run_op(0, 0, 0);
        run_op(5, 0, 0);
        step(0, 1, 0, 0, 0, 0, 1);
        step(0, 1, 1, 'h1f, 0, 0, 1);
        do_reset();
        step(0, 0, 0, 0, 0, 0, 1);

        // Counter saturation
        step(0, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) run_op(0, 0, 0);
        run_op(0, 0, 0);

        // Randomized episodes, including mid-run resets and stalls
        for (int ep = 0; ep < 40; ep++) begin
            do_reset();
            for (int i = 0; i < int'($urandom_range(0, 2)); i++) step(0, 0, 0, 0, 0, 0, 1);
            step(0, 1, 0, 0, 0, 0, 1);
            for (int i = 0; i < 40; i++) begin
                int  op;
                int  r;
                r  = int'($urandom_range(0, 99));
                op = (r < 30) ? 3 : (r < 60) ? 4 : (r < 62) ? 5 : int'($urandom_range(0, 7));
                step(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
                     1'($urandom_range(0, 1)), op, int'($urandom_range(0, PC_MOD - 1)),
                     1'($urandom_range(0, 1)),
                     ($urandom_range(0, 99) < 25) ? 1'b1 : 1'b0, 1);
            end
        end

        @(negedge CLK);
        #1;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
